// File: rtl/bram_dsp_seq_ctrl_if.sv
// Instruction handshake plus BRAM/DSP control bundle of the vector sequencer.
interface bram_dsp_seq_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 8
);
  localparam int unsigned INST_W = 5 + LEN_W + 3 * ADDR_W;

  logic [INST_W-1:0] inst;
  logic              inst_valid;
  logic              inst_ready;
  logic [ADDR_W-1:0] rd_addr_0;
  logic [ADDR_W-1:0] rd_addr_1;
  logic              en_rd_0;
  logic              en_rd_1;
  logic [ADDR_W-1:0] wr_addr;
  logic              en_wr;
  logic [4:0]        dsp_inmode;
  logic [6:0]        dsp_opmode;
  logic [3:0]        dsp_alumode;
  logic              busy;
  logic              done;
  logic              err;

  // Instruction source / status observer.
  modport master (
    output inst, inst_valid,
    input  inst_ready, rd_addr_0, rd_addr_1, en_rd_0, en_rd_1, wr_addr, en_wr,
    input  dsp_inmode, dsp_opmode, dsp_alumode, busy, done, err
  );

  // Sequencer side.
  modport slave (
    input  inst, inst_valid,
    output inst_ready, rd_addr_0, rd_addr_1, en_rd_0, en_rd_1, wr_addr, en_wr,
    output dsp_inmode, dsp_opmode, dsp_alumode, busy, done, err
  );
endinterface

// File: rtl/bram_dsp_seq_ctrl.sv
// Vector sequencer: streams operand reads, aligns DSP48 control with returning
// operands and issues delayed result write-backs.
module bram_dsp_seq_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned DSP_LAT = 3
) (
  input  logic               clk,
  input  logic               reset,
  bram_dsp_seq_ctrl_if.slave bus
);
  localparam int unsigned WB     = RD_LAT + DSP_LAT;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned INST_W = 5 + LEN_W + 3 * ADDR_W;

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(2);
  localparam logic [OP_W-1:0] OP_MAC = OP_W'(3);

  localparam logic [6:0] OPM_ADD  = 7'b0110011;
  localparam logic [6:0] OPM_MUL  = 7'b0000101;
  localparam logic [6:0] OPM_MACC = 7'b0100101;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0011;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  // One slot of the element pipe: DSP control plus the pending write-back.
  typedef struct packed {
    logic [6:0]        opm;
    logic [3:0]        alu;
    logic              wv;
    logic [ADDR_W-1:0] wa;
  } stage_t;

  logic [OP_W-1:0]   in_op;
  logic [LEN_W-1:0]  in_len;
  logic [ADDR_W-1:0] in_b0, in_b1, in_dst;
  logic              unused_rsvd;

  state_t            state_q;
  logic [OP_W-1:0]   op_q;
  logic [LEN_W-1:0]  len_q, idx_q;
  logic [ADDR_W-1:0] b0_q, b1_q, dst_q;
  logic              inst_ready_q, busy_q, done_q, err_q, en_rd_q;
  logic [ADDR_W-1:0] rd_addr_0_q, rd_addr_1_q;
  stage_t            pipe_q [WB+1];

  logic              accept_c, legal_c, issue_c, last_c, wb_pend_c;
  logic [OP_W-1:0]   sel_op;
  logic [LEN_W-1:0]  sel_len, sel_idx;
  logic [ADDR_W-1:0] sel_b0, sel_b1, sel_dst;
  logic [ADDR_W-1:0] rd_addr_0_d, rd_addr_1_d;
  stage_t            stage0_d;

  assign in_dst      = bus.inst[0 +: ADDR_W];
  assign in_b1       = bus.inst[ADDR_W +: ADDR_W];
  assign in_b0       = bus.inst[2*ADDR_W +: ADDR_W];
  assign in_len      = bus.inst[3*ADDR_W +: LEN_W];
  assign in_op       = bus.inst[3*ADDR_W+LEN_W +: OP_W];
  assign unused_rsvd = bus.inst[INST_W-1];

  // Pick the element to issue this edge: element 0 straight from the
  // instruction on acceptance, later elements from the latched fields.
  always_comb begin
    accept_c = bus.inst_valid & inst_ready_q;
    legal_c  = (in_op[3:2] == 2'b00);
    sel_op   = op_q;
    sel_len  = len_q;
    sel_idx  = idx_q;
    sel_b0   = b0_q;
    sel_b1   = b1_q;
    sel_dst  = dst_q;
    issue_c  = 1'b0;
    if (state_q == IDLE) begin
      sel_op  = in_op;
      sel_len = in_len;
      sel_idx = '0;
      sel_b0  = in_b0;
      sel_b1  = in_b1;
      sel_dst = in_dst;
      issue_c = accept_c & legal_c & (in_len != '0);
    end else if (state_q == ISSUE) begin
      issue_c = (idx_q != len_q);
    end
  end

  // Read addresses and stage-0 DSP/write-back payload for the issued element.
  always_comb begin
    last_c      = (sel_idx == LEN_W'(sel_len - LEN_W'(1)));
    rd_addr_0_d = '0;
    rd_addr_1_d = '0;
    stage0_d    = '0;
    if (issue_c) begin
      rd_addr_0_d = ADDR_W'(sel_b0 + ADDR_W'(sel_idx));
      rd_addr_1_d = ADDR_W'(sel_b1 + ADDR_W'(sel_idx));
      case (sel_op)
        OP_ADD:  begin stage0_d.opm = OPM_ADD; stage0_d.alu = ALU_ADD; end
        OP_SUB:  begin stage0_d.opm = OPM_ADD; stage0_d.alu = ALU_SUB; end
        OP_MUL:  begin stage0_d.opm = OPM_MUL; stage0_d.alu = ALU_ADD; end
        default: begin
          stage0_d.opm = (sel_idx == '0) ? OPM_MUL : OPM_MACC;
          stage0_d.alu = ALU_ADD;
        end
      endcase
      // Accumulate writes once, to dst, with the final element.
      if (sel_op != OP_MAC) begin
        stage0_d.wv = 1'b1;
        stage0_d.wa = ADDR_W'(sel_dst + ADDR_W'(sel_idx));
      end else if (last_c) begin
        stage0_d.wv = 1'b1;
        stage0_d.wa = sel_dst;
      end
    end
  end

  // Writes still in flight beyond the one presented this cycle.
  always_comb begin
    wb_pend_c = 1'b0;
    for (int unsigned j = 0; j < WB; j++) begin
      wb_pend_c = wb_pend_c | pipe_q[j].wv;
    end
  end

  // Control FSM with registered handshake, status and read outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      op_q         <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      b0_q         <= '0;
      b1_q         <= '0;
      dst_q        <= '0;
      inst_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      en_rd_q      <= 1'b0;
      rd_addr_0_q  <= '0;
      rd_addr_1_q  <= '0;
    end else begin
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      en_rd_q     <= issue_c;
      rd_addr_0_q <= rd_addr_0_d;
      rd_addr_1_q <= rd_addr_1_d;
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            if (!legal_c) begin
              err_q <= 1'b1;
            end else if (in_len == '0) begin
              done_q <= 1'b1;
            end else begin
              op_q         <= in_op;
              len_q        <= in_len;
              b0_q         <= in_b0;
              b1_q         <= in_b1;
              dst_q        <= in_dst;
              idx_q        <= LEN_W'(1);
              inst_ready_q <= 1'b0;
              busy_q       <= 1'b1;
              state_q      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (issue_c) begin
            idx_q <= LEN_W'(idx_q + LEN_W'(1));
          end else begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!wb_pend_c) begin
            done_q       <= 1'b1;
            inst_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Element pipe: DSP control taps off at RD_LAT, write-back at RD_LAT+DSP_LAT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned j = 0; j <= WB; j++) begin
        pipe_q[j] <= '0;
      end
    end else begin
      pipe_q[0] <= stage0_d;
      for (int unsigned j = 1; j <= WB; j++) begin
        pipe_q[j] <= pipe_q[j-1];
      end
    end
  end

  assign bus.inst_ready  = inst_ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.en_rd_0     = en_rd_q;
  assign bus.en_rd_1     = en_rd_q;
  assign bus.rd_addr_0   = rd_addr_0_q;
  assign bus.rd_addr_1   = rd_addr_1_q;
  assign bus.dsp_inmode  = 5'b00000;
  assign bus.dsp_opmode  = pipe_q[RD_LAT].opm;
  assign bus.dsp_alumode = pipe_q[RD_LAT].alu;
  assign bus.en_wr       = pipe_q[WB].wv;
  assign bus.wr_addr     = pipe_q[WB].wa;
endmodule

// File: tb/tb_bram_dsp_seq_ctrl.sv
// Bench for bram_dsp_seq_ctrl: instruction table with a per-event scoreboard,
// plus hand-written back-to-back, mid-run reset and longer-latency sequences.
module tb_bram_dsp_seq_ctrl;
  localparam int unsigned AW   = 8;
  localparam int unsigned LW   = 8;
  localparam int unsigned IW   = 5 + LW + 3 * AW;
  localparam int          RDL0 = 1;
  localparam int          WB0  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_dsp_seq_ctrl_if #(.ADDR_W(AW), .LEN_W(LW)) bus0 ();
  bram_dsp_seq_ctrl_if #(.ADDR_W(AW), .LEN_W(LW)) bus1 ();

  bram_dsp_seq_ctrl #(.ADDR_W(AW), .LEN_W(LW), .RD_LAT(1), .DSP_LAT(3)) dut0 (
    .clk(clk), .reset(rst_n), .bus(bus0)
  );
  bram_dsp_seq_ctrl #(.ADDR_W(AW), .LEN_W(LW), .RD_LAT(2), .DSP_LAT(4)) dut1 (
    .clk(clk), .reset(rst_n), .bus(bus1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int a; int b; } ev_t;
  typedef struct { int op; int len; int b0; int b1; int dst;
                   int exp_err; int exp_done; int exp_nwr; } vec_t;

  ev_t rd_q[$], dsp_q[$], wr_q[$];
  int  done_q[$], err_q[$];

  int n_vec = 0, n_bad = 0;
  bit mon_en = 1'b0;
  int busy_lo = 1, busy_hi = 0;
  int done_cyc = -1, err_cyc = -1, wr_cnt = 0;

  task automatic cmp(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_ev(input string nm, input int at);
    n_vec++;
    n_bad++;
    $display("FAIL %s: event at cyc %0d not as scheduled (now %0d)", nm, at, cyc);
  endtask

  function automatic logic [IW-1:0] mk_inst(input int op, input int len,
                                            input int b0, input int b1, input int dst);
    return {1'b0, 4'(op), LW'(len), AW'(b0), AW'(b1), AW'(dst)};
  endfunction

  // Expected events for an instruction accepted at edge k (cycle numbers = cyc).
  task automatic push_run(input int k, input int op, input int len,
                          input int b0, input int b1, input int dst);
    ev_t e;
    if (op >= 4) begin
      err_q.push_back(k + 1);
    end else if (len == 0) begin
      done_q.push_back(k + 1);
    end else begin
      for (int i = 0; i < len; i++) begin
        e.cyc = k + 1 + i; e.a = (b0 + i) % 256; e.b = (b1 + i) % 256;
        rd_q.push_back(e);
        e.cyc = k + 1 + i + RDL0;
        if (op == 2 || (op == 3 && i == 0)) e.a = 7'b0000101;
        else if (op == 3)                    e.a = 7'b0100101;
        else                                 e.a = 7'b0110011;
        e.b = (op == 1) ? 4'b0011 : 4'b0000;
        dsp_q.push_back(e);
        e.cyc = k + 1 + i + WB0; e.b = 0;
        if (op != 3) begin
          e.a = (dst + i) % 256; wr_q.push_back(e);
        end else if (i == len - 1) begin
          e.a = dst; wr_q.push_back(e);
        end
      end
      done_q.push_back(k + len + WB0 + 1);
      busy_lo = k + 1;
      busy_hi = k + len + WB0;
    end
  endtask

  task automatic drive0(input int op, input int len, input int b0, input int b1,
                        input int dst, output int k);
    int t = 0;
    @(negedge clk);
    while (!bus0.inst_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) fail_ev("ready_timeout", cyc);
    bus0.inst = mk_inst(op, len, b0, b1, dst);
    bus0.inst_valid = 1'b1;
    @(posedge clk); #1;
    bus0.inst_valid = 1'b0;
    k = cyc - 1;
    done_cyc = -1; err_cyc = -1; wr_cnt = 0;
    push_run(k, op, len, b0, b1, dst);
  endtask

  task automatic check_zero(input string p);
    cmp({p, "_rd_addr_0"}, int'(bus0.rd_addr_0), 0);
    cmp({p, "_rd_addr_1"}, int'(bus0.rd_addr_1), 0);
    cmp({p, "_en_rd_0"}, int'(bus0.en_rd_0), 0);
    cmp({p, "_en_rd_1"}, int'(bus0.en_rd_1), 0);
    cmp({p, "_wr_addr"}, int'(bus0.wr_addr), 0);
    cmp({p, "_en_wr"}, int'(bus0.en_wr), 0);
    cmp({p, "_inmode"}, int'(bus0.dsp_inmode), 0);
    cmp({p, "_opmode"}, int'(bus0.dsp_opmode), 0);
    cmp({p, "_alumode"}, int'(bus0.dsp_alumode), 0);
    cmp({p, "_busy"}, int'(bus0.busy), 0);
    cmp({p, "_done"}, int'(bus0.done), 0);
    cmp({p, "_err"}, int'(bus0.err), 0);
    cmp({p, "_inst_ready"}, int'(bus0.inst_ready), 1);
  endtask

  // Cycle monitor for dut0: every output event is matched against the scoreboard.
  always @(negedge clk) begin : mon
    ev_t e;
    int  x;
    if (mon_en) begin
      if (bus0.en_rd_0 || bus0.en_rd_1) begin
        if (rd_q.size() == 0) fail_ev("rd_unexpected", cyc);
        else begin
          e = rd_q.pop_front();
          cmp("rd_cyc", cyc, e.cyc);
          cmp("en_rd_0", int'(bus0.en_rd_0), 1);
          cmp("en_rd_1", int'(bus0.en_rd_1), 1);
          cmp("rd_addr_0", int'(bus0.rd_addr_0), e.a);
          cmp("rd_addr_1", int'(bus0.rd_addr_1), e.b);
        end
      end else if (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
        fail_ev("rd_missing", rd_q[0].cyc); void'(rd_q.pop_front());
      end

      if (bus0.dsp_opmode != 0 || bus0.dsp_alumode != 0 || bus0.dsp_inmode != 0) begin
        if (dsp_q.size() == 0) fail_ev("dsp_unexpected", cyc);
        else begin
          e = dsp_q.pop_front();
          cmp("dsp_cyc", cyc, e.cyc);
          cmp("dsp_opmode", int'(bus0.dsp_opmode), e.a);
          cmp("dsp_alumode", int'(bus0.dsp_alumode), e.b);
          cmp("dsp_inmode", int'(bus0.dsp_inmode), 0);
        end
      end else if (dsp_q.size() != 0 && dsp_q[0].cyc <= cyc) begin
        fail_ev("dsp_missing", dsp_q[0].cyc); void'(dsp_q.pop_front());
      end

      if (bus0.en_wr) begin
        wr_cnt++;
        if (wr_q.size() == 0) fail_ev("wr_unexpected", cyc);
        else begin
          e = wr_q.pop_front();
          cmp("wr_cyc", cyc, e.cyc);
          cmp("wr_addr", int'(bus0.wr_addr), e.a);
        end
      end else if (wr_q.size() != 0 && wr_q[0].cyc <= cyc) begin
        fail_ev("wr_missing", wr_q[0].cyc); void'(wr_q.pop_front());
      end

      if (bus0.done) begin
        done_cyc = cyc;
        if (done_q.size() == 0) fail_ev("done_unexpected", cyc);
        else begin x = done_q.pop_front(); cmp("done_cyc", cyc, x); end
      end else if (done_q.size() != 0 && done_q[0] <= cyc) begin
        fail_ev("done_missing", done_q[0]); void'(done_q.pop_front());
      end

      if (bus0.err) begin
        err_cyc = cyc;
        if (err_q.size() == 0) fail_ev("err_unexpected", cyc);
        else begin x = err_q.pop_front(); cmp("err_cyc", cyc, x); end
      end else if (err_q.size() != 0 && err_q[0] <= cyc) begin
        fail_ev("err_missing", err_q[0]); void'(err_q.pop_front());
      end

      x = (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0;
      cmp("busy", int'(bus0.busy), x);
      cmp("inst_ready", int'(bus0.inst_ready), 1 - x);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   k, k2, r, t, nw, wfirst, wlast, dcyc, dfirst;

    //        op len  b0   b1   dst  err done nwr
    vecs[0] = '{0, 5,   2,   3,  16,  0, 10,  5};
    vecs[1] = '{3, 4,  10,  20,  40,  0,  9,  1};
    vecs[2] = '{7, 3,   1,   2,   3,  1,  0,  0};
    vecs[3] = '{0, 0,   1,   2,   3,  0,  1,  0};
    vecs[4] = '{1, 4, 254, 255, 253,  0,  9,  4};
    vecs[5] = '{2, 3, 100, 200,   7,  0,  8,  3};
    vecs[6] = '{3, 1,   5,   6,  99,  0,  6,  1};
    vecs[7] = '{15, 0,  9,   9,   9,  1,  0,  0};
    vecs[8] = '{0, 1, 128, 129, 255,  0,  6,  1};

    bus0.inst = '0; bus0.inst_valid = 1'b0;
    bus1.inst = '0; bus1.inst_valid = 1'b0;
    #23;
    check_zero("por");
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Table of single instructions.
    for (int v = 0; v < 9; v++) begin
      drive0(vecs[v].op, vecs[v].len, vecs[v].b0, vecs[v].b1, vecs[v].dst, k);
      repeat (vecs[v].len + WB0 + 4) @(negedge clk);
      cmp("err_rel", (err_cyc < 0) ? 0 : err_cyc - k, vecs[v].exp_err);
      cmp("done_rel", (done_cyc < 0) ? 0 : done_cyc - k, vecs[v].exp_done);
      cmp("n_wr", wr_cnt, vecs[v].exp_nwr);
    end

    // Back-to-back with inst_valid held: second accepted in first's done cycle.
    @(negedge clk);
    bus0.inst = mk_inst(0, 2, 10, 20, 30);
    bus0.inst_valid = 1'b1;
    @(posedge clk); #1;
    k = cyc - 1;
    push_run(k, 0, 2, 10, 20, 30);
    bus0.inst = mk_inst(0, 2, 50, 60, 70);
    t = 0;
    r = 0;
    while (t < 50) begin
      @(negedge clk); r = int'(bus0.inst_ready);
      @(posedge clk); #1;
      t++;
      if (r == 1) break;
    end
    bus0.inst_valid = 1'b0;
    if (r != 1) fail_ev("b2b_accept_timeout", cyc);
    k2 = cyc - 1;
    cmp("b2b_accept_cyc", k2, k + 2 + WB0 + 1);
    push_run(k2, 0, 2, 50, 60, 70);
    wr_cnt = 0;
    repeat (2 + WB0 + 4) @(negedge clk);
    cmp("b2b_n_wr2", wr_cnt, 2);

    // Reset asserted in cycle 3 of an 8-element run.
    drive0(0, 8, 0, 100, 200, k);
    while (cyc < k + 3) @(posedge clk);
    #2;
    mon_en = 1'b0;
    rd_q.delete(); dsp_q.delete(); wr_q.delete(); done_q.delete(); err_q.delete();
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    repeat (3) @(negedge clk);
    check_zero("rst_hold");
    rst_n = 1'b1;
    busy_lo = 1; busy_hi = 0; wr_cnt = 0;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    cmp("rst_stale_wr", wr_cnt, 0);

    // Longer latencies: RD_LAT=2, DSP_LAT=4 on the second instance.
    @(negedge clk);
    bus1.inst = mk_inst(0, 5, 2, 3, 16);
    bus1.inst_valid = 1'b1;
    @(posedge clk); #1;
    bus1.inst_valid = 1'b0;
    k = cyc - 1;
    nw = 0; wfirst = -1; wlast = -1; dcyc = -1; dfirst = -1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus1.en_wr) begin
        cmp("lat2_wr_addr", int'(bus1.wr_addr), 16 + nw);
        if (nw == 0) wfirst = cyc;
        wlast = cyc;
        nw++;
      end
      if (bus1.dsp_opmode != 0 && dfirst < 0) dfirst = cyc;
      if (bus1.done) dcyc = cyc;
    end
    cmp("lat2_n_wr", nw, 5);
    cmp("lat2_first_wr", wfirst - k, 7);
    cmp("lat2_last_wr", wlast - k, 11);
    cmp("lat2_done", dcyc - k, 12);
    cmp("lat2_first_dsp", dfirst - k, 3);

    @(negedge clk);
    cmp("left_rd", rd_q.size(), 0);
    cmp("left_dsp", dsp_q.size(), 0);
    cmp("left_wr", wr_q.size(), 0);
    cmp("left_done", done_q.size(), 0);
    cmp("left_err", err_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
